odd_parity_scheduler: RTL and testbench
=======================================

// Module: odd_parity_scheduler
//
// PURPOSE
//  Shares one odd-parity checking datapath between NUM_REQ requesters via round-robin arbitration.
//  Each requester offers a DATA_W-bit word on a valid/ready handshake.
//  The block grants one requester, registers its word and computes the XOR-reduction parity.
//  It returns the result with the requester ID on a valid/ready response port.
//  Per-requester saturating counters track words that fail odd parity.
//  It sits between the bus-side requesters and the shared parity checker.
//
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  DATA_W   16  width of checked word
//  CNT_W    8   width of each per-requester error counter
//
// PORTS
//  clk         in   1                clock, rising edge
//  rst         in   1                asynchronous reset, active-high
//  req_valid   in   NUM_REQ          requester i has a word pending
//  req_data    in   NUM_REQ*DATA_W   word of requester i at [i*DATA_W +: DATA_W]
//  req_ready   out  NUM_REQ          one-hot grant; word i accepted when valid&ready
//  rsp_valid   out  1                result available
//  rsp_ready   in   1                consumer accepts result
//  rsp_id      out  $clog2(NUM_REQ)  requester index of result
//  rsp_parity  out  1                ^word: 1 = odd count of ones (pass), 0 = fail
//  clr_cnt     in   1                synchronous clear of all error counters
//  err_cnt     out  NUM_REQ*CNT_W    counter i at [i*CNT_W +: CNT_W]
//
// BEHAVIOUR
//  Reset (async, rst=1):
//  - state=IDLE, rr_ptr=0, captured word=0.
//  - All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_parity and err_cnt.
//  FSM states are IDLE, CHECK and RESP.
//  - IDLE: if any req_valid, req_ready asserts combinationally for exactly one requester g.
//    g is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//    On that edge: capture req_data[g] and g, set rr_ptr=(g+1)%NUM_REQ, go to CHECK.
//    With no valid, stay in IDLE with req_ready=0.
//  - CHECK: register rsp_parity = ^word and rsp_id = g, then go to RESP. req_ready=0.
//  - RESP: rsp_valid=1. rsp_id and rsp_parity stay stable until rsp_ready.
//    On rsp_valid&rsp_ready go to IDLE.
//  - req_ready=0 in CHECK and RESP. rsp_valid=0 in IDLE and CHECK.
//  Latency and throughput:
//  - Accept at edge N gives rsp_valid=1 from the cycle after edge N+1 (2 cycles).
//  - Minimum spacing between accepts is 3 cycles (IDLE->CHECK->RESP->IDLE).
//  Requester-side rules:
//  - A requester holds valid and data until it sees ready.
//  - Dropping valid without a grant is allowed and is not an error.
//  Error counters:
//  - On the response handshake with rsp_parity=0, err_cnt[rsp_id] increments.
//  - Counters saturate at 2^CNT_W-1 and do not wrap.
//  - clr_cnt=1 zeroes all counters on the next edge.
//  - clr_cnt takes priority over a same-cycle increment; the result is 0.
//  Mid-operation reset: rst in any state aborts at once. An in-flight word is discarded
//  with no response and the counters clear.
//  Requester index NUM_REQ-1 wraps rr_ptr to 0.
//
// TESTING
//  1 Single: req0 valid, data 16'h0001 -> grant req0; after 2 cycles rsp_id=0, rsp_parity=1; err_cnt0 stays 0.
//  2 Fairness: all four valid, words held -> grant order 0,1,2,3,0; rsp_id matches each grant.
//  3 Fail: req2 data 16'h0003, rsp_ready held 0 for 5 cycles -> rsp stable with rsp_id=2, rsp_parity=0.
//    Then rsp_ready=1 -> err_cnt2=1 and state returns to IDLE.
//  4 Saturate/clear: CNT_W=8, 260 failing words from req1 -> err_cnt1=255.
//    Then clr_cnt together with a failing handshake -> err_cnt1=0.
//  5 Reset mid-op: rst asserted in CHECK -> outputs 0 immediately, no rsp_valid after release, rr_ptr=0.
//  6 Wrap: rr_ptr=3, only req3 and req0 valid -> grant 3, then 0.

Source files
------------

// File: rtl/odd_parity_scheduler.sv
// odd_parity_scheduler
// Round-robin arbiter in front of a single odd-parity checker.
// One word is in flight at a time. Each word is granted in IDLE, reduced in CHECK,
// and held on the response port in RESP until the consumer takes it.
// Each requester has a saturating counter of words that failed odd parity.
module odd_parity_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_parity,
  input  logic                       clr_cnt,
  output logic [NUM_REQ*CNT_W-1:0]   err_cnt
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // The scan index needs one spare bit so that rr_ptr + offset can exceed
  // NUM_REQ-1 before it is folded back into range.
  localparam int PTR_W = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_parity_q, rsp_parity_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [DATA_W-1:0]   grant_word;

  logic                rsp_hs;
  logic                fail_hs;

  // Round-robin search: the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + PTR_W'(k);
      if (scan_idx >= PTR_W'(NUM_REQ)) begin
        scan_idx = scan_idx - PTR_W'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Expand the winning index into a one-hot vector, one bit per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_found && (grant_idx == ID_W'(gi));
    end
  endgenerate

  assign grant_word = req_data[grant_idx*DATA_W +: DATA_W];

  // Grants are offered only in IDLE. They are also masked while rst is high,
  // so that every output reads 0 during reset even if a requester is already valid.
  assign req_ready = (state_q == IDLE && !rst) ? grant_onehot : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_parity = rsp_parity_q;

  assign rsp_hs  = rsp_valid & rsp_ready;
  assign fail_hs = rsp_hs & ~rsp_parity_q;

  // Next-state logic for the FSM and the datapath registers it steers.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gid_d        = gid_q;
    word_d       = word_q;
    rsp_id_d     = rsp_id_q;
    rsp_parity_d = rsp_parity_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          word_d   = grant_word;
          gid_d    = grant_idx;
          // The last requester wraps the pointer explicitly.
          // This stays correct when NUM_REQ is not a power of two.
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        rsp_parity_d = ^word_q;
        rsp_id_d     = gid_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gid_q        <= '0;
      word_q       <= '0;
      rsp_id_q     <= '0;
      rsp_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gid_q        <= gid_d;
      word_q       <= word_d;
      rsp_id_q     <= rsp_id_d;
      rsp_parity_q <= rsp_parity_d;
    end
  end

  // Per-requester error counters. A counter bumps on a failing response handshake for its ID.
  // It saturates at all-ones, and clr_cnt overrides a same-cycle bump.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Next value for this requester's counter.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
          cnt_d = '0;
        end else if (fail_hs && (rsp_id_q == ID_W'(gi)) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign err_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_odd_parity_scheduler.sv
// Testbench for odd_parity_scheduler.
// The bench drives table-driven grants and checks responses through a scoreboard queue.
// It also runs hand-written sequences for saturation, clear, mid-operation reset and pointer wrap.
module tb_odd_parity_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_parity;
  logic        clr_cnt;
  logic [31:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_err[NUM_REQ];

  typedef struct {
    int   id;
    logic par;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic mon_fail;

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] data;
    int          exp_id;
    logic        exp_par;
    int          hold;
  } vec_t;
  vec_t vecs[9];

  odd_parity_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_parity(rsp_parity),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_err();
    for (int i = 0; i < NUM_REQ; i++) begin
      check($sformatf("err_cnt%0d", i), 64'(err_cnt[i*CNT_W +: CNT_W]), 64'(exp_err[i]));
    end
  endtask

  // Scoreboard consumer. It pops one expectation per response handshake and keeps the counter model in step.
  always @(negedge clk) begin
    if (!rst) begin
      mon_fail = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=id%0d required=no response", rsp_id);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_rsp_id", 64'(rsp_id), 64'(mon_e.id));
          check("sb_rsp_parity", 64'(rsp_parity), 64'(mon_e.par));
          mon_fail = !mon_e.par;
          $display("txn rsp id=%0d parity=%0b", rsp_id, rsp_parity);
        end
      end
      if (clr_cnt) begin
        for (int i = 0; i < NUM_REQ; i++) exp_err[i] = 0;
      end else if (mon_fail && exp_err[mon_e.id] < 255) begin
        exp_err[mon_e.id]++;
      end
    end
  end

  // Runs one full transaction: offer, grant, CHECK, RESP (held for hold extra cycles),
  // then the handshake (optionally with clr_cnt) and a counter check.
  task automatic issue(input logic [3:0] mask, input logic [63:0] data, input int exp_id,
                       input logic exp_par, input int hold, input logic clr);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = mask;
    req_data  = data;
    rsp_ready = 1'b0;
    clr_cnt   = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout actual=none required=req%0d", exp_id);
      req_valid = 4'b0;
      return;
    end
    check("grant", 64'(req_ready), 64'(4'b0001 << exp_id));
    sbq.push_back('{exp_id, exp_par});
    @(posedge clk); #1;
    req_valid = 4'b0;
    @(negedge clk);
    check("check_rsp_valid", 64'(rsp_valid), 64'd0);
    check("check_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("resp_valid", 64'(rsp_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'(exp_id));
      check("hold_parity", 64'(rsp_parity), 64'(exp_par));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    clr_cnt   = clr;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    clr_cnt   = 1'b0;
    @(negedge clk);
    check("idle_after_hs", 64'(rsp_valid), 64'd0);
    check_err();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    // Fairness: all valid with words held. Word parities are 0,1,0,1 for req0..req3.
    vecs[0] = '{4'b1111, 64'h8000_00FF_0007_0003, 0, 1'b0, 0};
    vecs[1] = '{4'b1111, 64'h8000_00FF_0007_0003, 1, 1'b1, 0};
    vecs[2] = '{4'b1111, 64'h8000_00FF_0007_0003, 2, 1'b0, 0};
    vecs[3] = '{4'b1111, 64'h8000_00FF_0007_0003, 3, 1'b1, 0};
    vecs[4] = '{4'b1111, 64'h8000_00FF_0007_0003, 0, 1'b0, 0};
    // Single req0 with a passing word (rr_ptr=1 here).
    vecs[5] = '{4'b0001, 64'h0000_0000_0000_0001, 0, 1'b1, 0};
    // req2 with a failing word, held for 5 cycles with rsp_ready=0.
    vecs[6] = '{4'b0100, 64'h0000_0003_0000_0000, 2, 1'b0, 5};
    // Wrap: rr_ptr=3 with req3 and req0 valid gives 3, then 0.
    vecs[7] = '{4'b1001, 64'hFFFF_0000_0000_1234, 3, 1'b0, 0};
    vecs[8] = '{4'b1001, 64'hFFFF_0000_0000_1234, 0, 1'b1, 0};

    for (int i = 0; i < NUM_REQ; i++) exp_err[i] = 0;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 64'h0;
    rsp_ready = 1'b0;
    clr_cnt   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_parity", 64'(rsp_parity), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b0;

    for (int v = 0; v < 9; v++) begin
      $display("txn vec=%0d mask=%b exp_id=%0d exp_par=%0b", v, vecs[v].mask, vecs[v].exp_id, vecs[v].exp_par);
      issue(vecs[v].mask, vecs[v].data, vecs[v].exp_id, vecs[v].exp_par, vecs[v].hold, 1'b0);
    end

    // Saturation: 260 failing words from req1.
    for (int n = 0; n < 260; n++) begin
      issue(4'b0010, 64'h0000_0000_0003_0000, 1, 1'b0, 0, 1'b0);
    end
    check("sat_err_cnt1", 64'(err_cnt[15:8]), 64'd255);
    // A clear on the same edge as a failing handshake leaves 0.
    issue(4'b0010, 64'h0000_0000_0003_0000, 1, 1'b0, 0, 1'b1);
    check("clr_err_cnt1", 64'(err_cnt[15:8]), 64'd0);

    // Mid-operation reset: grant req2 (rr_ptr=2), then assert rst while the DUT is in CHECK.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data  = 64'h0000_0003_0000_0000;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) got = 1'b1;
    end
    check("mid_rst_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
    check("mid_rst_rsp_parity", 64'(rsp_parity), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    sbq.delete();
    for (int i = 0; i < NUM_REQ; i++) exp_err[i] = 0;
    req_valid = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    // rr_ptr must be back at 0, so an all-valid offer grants req0.
    issue(4'b1111, 64'h8000_00FF_0007_0003, 0, 1'b0, 0, 1'b0);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
